// File: rtl/fir_lowpass_serial_mac_if.sv
// Sample/coefficient/result bundle for the serial-MAC FIR filter.
// Pure wiring, no latency.
// No flow control: the master strobes, the slave reports BUSY/OVERRUN.
interface fir_lowpass_serial_mac_if #(
  parameter int BITWIDTH_DATA  = 12,
  parameter int BITWIDTH_COEFF = 12,
  parameter int LENGTH         = 8
);
  localparam int ADR_W = $clog2(LENGTH);

  logic                             EN;
  logic                             START_FLAG;
  logic signed [BITWIDTH_DATA-1:0]  DATA_IN;
  logic                             COEFF_WE;
  logic        [ADR_W-1:0]          COEFF_ADR;
  logic signed [BITWIDTH_COEFF-1:0] COEFF_DATA;
  logic signed [BITWIDTH_DATA-1:0]  DATA_OUT;
  logic                             DATA_VALID;
  logic                             BUSY;
  logic                             OVERRUN;

  modport master (
    output EN, START_FLAG, DATA_IN, COEFF_WE, COEFF_ADR, COEFF_DATA,
    input  DATA_OUT, DATA_VALID, BUSY, OVERRUN
  );

  modport slave (
    input  EN, START_FLAG, DATA_IN, COEFF_WE, COEFF_ADR, COEFF_DATA,
    output DATA_OUT, DATA_VALID, BUSY, OVERRUN
  );
endinterface

// File: rtl/fir_lowpass_serial_mac.sv
// Time-multiplexed FIR filter: one shared multiplier, LENGTH taps, run-time coefficients.
// Latency LENGTH+2 clocks from START_FLAG to the DATA_VALID pulse; one sample per LENGTH+3 clocks.
// No backpressure: a strobe arriving while BUSY is dropped and latched into sticky OVERRUN.
module fir_lowpass_serial_mac #(
  parameter int BITWIDTH_DATA  = 12,
  parameter int BITWIDTH_COEFF = 12,
  parameter int LENGTH         = 8
) (
  input logic CLK,
  input logic nRST,
  fir_lowpass_serial_mac_if.slave bus
);
  localparam int ADR_W  = $clog2(LENGTH);
  localparam int PROD_W = BITWIDTH_DATA + BITWIDTH_COEFF;
  localparam int ACC_W  = PROD_W + ADR_W;
  localparam logic [ADR_W-1:0]        TAP_LAST = ADR_W'(LENGTH - 1);
  localparam logic signed [ACC_W:0]   RND_HALF = (ACC_W+1)'(2 ** (BITWIDTH_COEFF - 2));
  localparam logic signed [ACC_W:0]   OUT_MAX  = (ACC_W+1)'(2 ** (BITWIDTH_DATA - 1) - 1);
  localparam logic signed [ACC_W:0]   OUT_MIN  = (ACC_W+1)'(-(2 ** (BITWIDTH_DATA - 1)));

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_MAC, ST_OUT} state_t;

  state_t                           state, state_nxt;
  logic signed [BITWIDTH_DATA-1:0]  hist  [LENGTH];
  logic signed [BITWIDTH_COEFF-1:0] coeff [LENGTH];
  logic signed [BITWIDTH_DATA-1:0]  sample_q;
  logic        [ADR_W-1:0]          wptr, tap, rd_adr;
  logic        [ADR_W:0]            rd_diff, rd_wrap;
  logic signed [PROD_W-1:0]         product;
  logic signed [ACC_W-1:0]          acc;
  logic signed [ACC_W:0]            acc_rnd, acc_shf;
  logic signed [BITWIDTH_DATA-1:0]  result;
  logic signed [BITWIDTH_DATA-1:0]  data_out;
  logic                             data_valid, overrun;
  logic        [31:0]               adr_ext;
  logic                             coeff_wr;

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: accept in IDLE, one WRITE cycle, LENGTH MAC cycles, one OUT cycle; EN low forces IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.START_FLAG) state_nxt = ST_WRITE;
      ST_WRITE: state_nxt = ST_MAC;
      ST_MAC:   if (tap == TAP_LAST) state_nxt = ST_OUT;
      ST_OUT:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (!bus.EN) state_nxt = ST_IDLE;
  end

  // History address (wptr - tap) mod LENGTH; works for non power-of-two LENGTH too
  always_comb begin
    rd_diff = {1'b0, wptr} - {1'b0, tap};
    rd_wrap = rd_diff + (ADR_W+1)'(LENGTH);
    rd_adr  = rd_diff[ADR_W] ? rd_wrap[ADR_W-1:0] : rd_diff[ADR_W-1:0];
  end

  assign product = PROD_W'(coeff[tap]) * PROD_W'(hist[rd_adr]);

  // Round half toward +inf, then drop the Q1.(BITWIDTH_COEFF-1) fraction
  assign acc_rnd = {acc[ACC_W-1], acc} + RND_HALF;
  assign acc_shf = acc_rnd >>> (BITWIDTH_COEFF - 1);

  // Saturate the rounded sum to the output sample range
  always_comb begin
    result = acc_shf[BITWIDTH_DATA-1:0];
    if (acc_shf > OUT_MAX)      result = OUT_MAX[BITWIDTH_DATA-1:0];
    else if (acc_shf < OUT_MIN) result = OUT_MIN[BITWIDTH_DATA-1:0];
  end

  // Datapath: sample latch, history ring, write pointer, tap counter and accumulator
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sample_q <= '0;
      wptr     <= '0;
      tap      <= '0;
      acc      <= '0;
      for (int i = 0; i < LENGTH; i++) hist[i] <= '0;
    end else if (!bus.EN) begin
      sample_q <= '0;
      wptr     <= '0;
      tap      <= '0;
      acc      <= '0;
      for (int i = 0; i < LENGTH; i++) hist[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: if (bus.START_FLAG) sample_q <= bus.DATA_IN;
        ST_WRITE: begin
          hist[wptr] <= sample_q;
          acc        <= '0;
          tap        <= '0;
        end
        ST_MAC: begin
          acc <= acc + ACC_W'(product);
          tap <= tap + 1'b1;
        end
        ST_OUT: wptr <= (wptr == TAP_LAST) ? '0 : wptr + 1'b1;
        default: ;
      endcase
    end
  end

  assign adr_ext  = 32'(bus.COEFF_ADR);
  assign coeff_wr = bus.COEFF_WE && (state == ST_IDLE) && (adr_ext < LENGTH);

  // Coefficient bank: written only while idle, survives EN low
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < LENGTH; i++) coeff[i] <= '0;
    end else if (coeff_wr) begin
      coeff[bus.COEFF_ADR] <= bus.COEFF_DATA;
    end
  end

  // Result register, valid pulse and sticky overrun flag
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (!bus.EN) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      data_valid <= (state == ST_OUT);
      if (state == ST_OUT) data_out <= result;
      if (bus.START_FLAG && (state != ST_IDLE)) overrun <= 1'b1;
    end
  end

  assign bus.DATA_OUT   = data_out;
  assign bus.DATA_VALID = data_valid;
  assign bus.BUSY       = (state != ST_IDLE);
  assign bus.OVERRUN    = overrun;
endmodule

// File: tb/tb_fir_lowpass_serial_mac.sv
// Directed bench for the serial-MAC FIR: table of {coeff set, input, expected output}
// plus hand-written sequences for overrun/wrap, coefficient-write timing and aborts.
module tb_fir_lowpass_serial_mac;
  localparam int BD = 12;
  localparam int BC = 12;
  localparam int LEN = 8;
  localparam int AW = $clog2(LEN);

  logic CLK = 1'b0;
  logic nRST;
  int errors = 0;
  int checks = 0;

  fir_lowpass_serial_mac_if #(.BITWIDTH_DATA(BD), .BITWIDTH_COEFF(BC), .LENGTH(LEN)) bus();

  fir_lowpass_serial_mac #(.BITWIDTH_DATA(BD), .BITWIDTH_COEFF(BC), .LENGTH(LEN)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  // mode 0 = continue; 1 = {1024,512,0..}; 2 = {1,0..}; 3 = all 1024 (non-zero mode clears history first)
  typedef struct {
    int mode;
    int din;
    int exp_out;
  } vec_t;

  vec_t vecs [0:26];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic en_clear();
    bus.EN = 1'b0;
    step();
    bus.EN = 1'b1;
  endtask

  task automatic wr_coeff(input int adr, input int val);
    bus.COEFF_WE   = 1'b1;
    bus.COEFF_ADR  = AW'(adr);
    bus.COEFF_DATA = BC'(val);
    step();
    bus.COEFF_WE   = 1'b0;
  endtask

  task automatic load_mode(input int m);
    for (int j = 0; j < LEN; j++) begin
      if (m == 1)      wr_coeff(j, (j == 0) ? 1024 : (j == 1) ? 512 : 0);
      else if (m == 2) wr_coeff(j, (j == 0) ? 1 : 0);
      else             wr_coeff(j, 1024);
    end
  endtask

  // we_mode 1: COEFF_WE high in the strobe cycle; 2: COEFF_WE high only while busy
  task automatic run_sample(input int x, input int we_mode, output int y, output int lat,
                            output int busy_cnt);
    if (we_mode == 1) bus.COEFF_WE = 1'b1;
    bus.START_FLAG = 1'b1;
    bus.DATA_IN    = BD'(x);
    step();
    bus.START_FLAG = 1'b0;
    bus.COEFF_WE   = (we_mode == 2);
    lat = -1;
    busy_cnt = 0;
    y = 0;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      step();
      if (i == 9) bus.COEFF_WE = 1'b0;
      if (bus.BUSY) busy_cnt++;
      if (bus.DATA_VALID) begin
        lat = i;
        y = bus.DATA_OUT;
      end
    end
    bus.COEFF_WE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int y, lat, bcnt, vcnt;

    vecs[0] = '{1, 1000, 500};
    vecs[1] = '{0, 0, 250};
    vecs[2] = '{0, 0, 0};
    vecs[3] = '{0, 0, 0};
    vecs[4] = '{2, 1024, 1};
    vecs[5] = '{0, -1024, 0};
    vecs[6] = '{0, 2047, 1};
    vecs[7] = '{0, -2048, -1};
    vecs[8] = '{0, 1023, 0};
    vecs[9] = '{3, 2047, 1024};
    vecs[10] = '{0, 2047, 2047};
    for (int i = 11; i <= 16; i++) vecs[i] = '{0, 2047, 2047};
    vecs[17] = '{3, -2048, -1024};
    for (int i = 18; i <= 24; i++) vecs[i] = '{0, -2048, -2048};
    vecs[25] = '{3, 2047, 1024};
    vecs[26] = '{0, -2048, 0};

    nRST = 1'b0;
    bus.EN = 1'b0;
    bus.START_FLAG = 1'b0;
    bus.DATA_IN = '0;
    bus.COEFF_WE = 1'b0;
    bus.COEFF_ADR = '0;
    bus.COEFF_DATA = '0;
    step();
    step();
    check("reset_data_out", bus.DATA_OUT, 0);
    check("reset_data_valid", bus.DATA_VALID, 0);
    check("reset_busy", bus.BUSY, 0);
    check("reset_overrun", bus.OVERRUN, 0);
    nRST = 1'b1;
    bus.EN = 1'b1;
    step();

    // Table-driven vectors at the maximum sample rate (no idle gap beyond the valid check)
    for (int i = 0; i < 27; i++) begin
      if (vecs[i].mode != 0) begin
        en_clear();
        load_mode(vecs[i].mode);
      end
      run_sample(vecs[i].din, 0, y, lat, bcnt);
      check($sformatf("vec%0d_out", i), y, vecs[i].exp_out);
      check($sformatf("vec%0d_latency", i), lat, LEN + 2);
      check($sformatf("vec%0d_busy_cycles", i), bcnt, LEN + 1);
      step();
      check($sformatf("vec%0d_valid_pulse", i), bus.DATA_VALID, 0);
    end

    // Coefficient write in the strobe cycle is used by that computation: c0=512 -> 250
    en_clear();
    load_mode(1);
    bus.COEFF_ADR = '0;
    bus.COEFF_DATA = BC'(512);
    run_sample(1000, 1, y, lat, bcnt);
    check("same_cycle_coeff_out", y, 250);

    // Coefficient writes while busy are ignored: c0 stays 512 -> 512*1000+512*1000 -> 500
    bus.COEFF_ADR = '0;
    bus.COEFF_DATA = BC'(1024);
    run_sample(1000, 2, y, lat, bcnt);
    check("busy_coeff_write_ignored", y, 500);

    // Overrun: second strobe 3 clocks after the first is dropped; first result intact
    en_clear();
    load_mode(1);
    bus.START_FLAG = 1'b1;
    bus.DATA_IN = BD'(1000);
    step();
    bus.START_FLAG = 1'b0;
    step();
    step();
    bus.START_FLAG = 1'b1;
    bus.DATA_IN = BD'(2000);
    step();
    bus.START_FLAG = 1'b0;
    check("overrun_set", bus.OVERRUN, 1);
    lat = -1;
    y = 0;
    for (int i = 4; i <= 20 && lat < 0; i++) begin
      step();
      if (bus.DATA_VALID) begin
        lat = i;
        y = bus.DATA_OUT;
      end
    end
    check("overrun_first_latency", lat, LEN + 2);
    check("overrun_first_out", y, 500);
    run_sample(0, 0, y, lat, bcnt);
    check("overrun_dropped_sample", y, 250);

    // 20 spaced impulses across several write-pointer wraps
    for (int i = 0; i < 20; i++) begin
      run_sample((i % 3 == 0) ? 1000 : 0, 0, y, lat, bcnt);
      check($sformatf("wrap%0d_out", i), y, (i % 3 == 0) ? 500 : (i % 3 == 1) ? 250 : 0);
    end
    check("overrun_sticky", bus.OVERRUN, 1);

    // EN low mid-MAC: aborted, no valid, overrun cleared, coefficients kept
    bus.START_FLAG = 1'b1;
    bus.DATA_IN = BD'(1000);
    step();
    bus.START_FLAG = 1'b0;
    step();
    step();
    step();
    bus.EN = 1'b0;
    step();
    bus.EN = 1'b1;
    check("en_abort_busy", bus.BUSY, 0);
    check("en_abort_data_out", bus.DATA_OUT, 0);
    check("en_abort_overrun", bus.OVERRUN, 0);
    vcnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.DATA_VALID) vcnt++;
    end
    check("en_abort_no_valid", vcnt, 0);
    run_sample(1000, 0, y, lat, bcnt);
    check("en_abort_next_out", y, 500);
    check("en_abort_next_latency", lat, LEN + 2);

    // nRST low mid-MAC: outputs clear at once, coefficients zeroed
    bus.START_FLAG = 1'b1;
    bus.DATA_IN = BD'(1000);
    step();
    bus.START_FLAG = 1'b0;
    step();
    step();
    step();
    #2;
    nRST = 1'b0;
    #1;
    check("rst_abort_data_out", bus.DATA_OUT, 0);
    check("rst_abort_busy", bus.BUSY, 0);
    check("rst_abort_valid", bus.DATA_VALID, 0);
    step();
    nRST = 1'b1;
    step();
    run_sample(1000, 0, y, lat, bcnt);
    check("rst_abort_coeff_zero_out", y, 0);
    check("rst_abort_latency", lat, LEN + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
